// File: rtl/i2c_word_init_sequencer.sv
// i2c_word_init_sequencer: walks a (pointer, data) register table and issues
// one 16-bit word write per entry through the I2C engine GO/END_OK handshake,
// retrying on final-byte NACK and reporting DONE or ERR with index and code.
// Ports: PT_CK/RESET_N clock and async active-low reset; START level (rising
// edge begins a run); TBL_* table read port; I2C_* engine command/status;
// BUSY/DONE/ERR/ERR_IDX/ERR_CODE run status.
module i2c_word_init_sequencer #(
  parameter int         NUM_WORDS  = 8,
  parameter logic [7:0] SLAVE_ADDR = 8'h90,
  parameter int         GO_PULSE   = 4,
  parameter int         GAP_CYCLES = 16,
  parameter int         MAX_RETRY  = 2,
  parameter int         START_TMO  = 64,
  parameter int         XFER_TMO   = 4096
) (
  input  logic        PT_CK,
  input  logic        RESET_N,
  input  logic        START,
  output logic [7:0]  TBL_IDX,
  input  logic [7:0]  TBL_POINTER,
  input  logic [15:0] TBL_DATA,
  output logic        I2C_GO,
  output logic [7:0]  I2C_SLAVE_ADDRESS,
  output logic [7:0]  I2C_POINTER,
  output logic [15:0] I2C_WDATA16,
  input  logic        I2C_END_OK,
  input  logic        I2C_ACK_OK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  ERR_IDX,
  output logic [1:0]  ERR_CODE
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH1, S_FETCH2, S_GO_HI, S_WAIT_START,
    S_WAIT_END, S_CHECK, S_GAP, S_FINISH, S_ABORT
  } state_t;

  localparam logic [12:0] GO_LAST    = 13'(GO_PULSE - 1);
  localparam logic [12:0] GAP_LAST   = 13'(GAP_CYCLES - 1);
  localparam logic [12:0] START_LAST = 13'(START_TMO - 1);
  localparam logic [12:0] XFER_LAST  = 13'(XFER_TMO - 1);
  localparam logic [7:0]  IDX_LAST   = 8'(NUM_WORDS - 1);
  localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);

  state_t      state, state_n;
  logic [12:0] cnt, cnt_n;
  logic [7:0]  idx, idx_n;
  logic [7:0]  retry, retry_n;
  logic [7:0]  ptr, ptr_n;
  logic [15:0] wdata, wdata_n;
  logic        busy, busy_n;
  logic        done, done_n;
  logic        err, err_n;
  logic [7:0]  err_idx, err_idx_n;
  logic [1:0]  err_code, err_code_n;
  logic        refetch, refetch_n;
  logic        ack_st, ack_st_n;
  logic        ack_q;
  logic        start_q;
  logic        start_rise;

  assign start_rise        = START & ~start_q;
  assign I2C_GO            = (state == S_GO_HI);
  assign I2C_SLAVE_ADDRESS = SLAVE_ADDR;
  assign I2C_POINTER       = ptr;
  assign I2C_WDATA16       = wdata;
  assign TBL_IDX           = idx;
  assign BUSY              = busy;
  assign DONE              = done;
  assign ERR               = err;
  assign ERR_IDX           = err_idx;
  assign ERR_CODE          = err_code;

  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      retry    <= '0;
      ptr      <= '0;
      wdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_idx  <= '0;
      err_code <= '0;
      refetch  <= 1'b0;
      ack_st   <= 1'b0;
      ack_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      retry    <= retry_n;
      ptr      <= ptr_n;
      wdata    <= wdata_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      err_idx  <= err_idx_n;
      err_code <= err_code_n;
      refetch  <= refetch_n;
      ack_st   <= ack_st_n;
      // ACK_OK clears on the edge END_OK rises, so the previous sample is kept.
      ack_q    <= I2C_ACK_OK;
      start_q  <= START;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    retry_n    = retry;
    ptr_n      = ptr;
    wdata_n    = wdata;
    busy_n     = busy;
    done_n     = done;
    err_n      = err;
    err_idx_n  = err_idx;
    err_code_n = err_code;
    refetch_n  = refetch;
    ack_st_n   = ack_st;

    unique case (state)
      S_IDLE: begin
        if (start_rise) begin
          done_n     = 1'b0;
          err_n      = 1'b0;
          err_code_n = '0;
          err_idx_n  = '0;
          idx_n      = '0;
          retry_n    = '0;
          busy_n     = 1'b1;
          state_n    = S_FETCH1;
        end
      end
      S_FETCH1: state_n = S_FETCH2;
      S_FETCH2: begin
        ptr_n   = TBL_POINTER;
        wdata_n = TBL_DATA;
        if (TBL_POINTER == 8'hFF && TBL_DATA == 16'hFFFF) state_n = S_FINISH;
        else                                              state_n = S_GO_HI;
      end
      S_GO_HI: begin
        if (cnt == GO_LAST) state_n = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!I2C_END_OK) begin
          state_n = S_WAIT_END;
        end else if (cnt == START_LAST) begin
          err_code_n = 2'd2;
          state_n    = S_ABORT;
        end
      end
      S_WAIT_END: begin
        if (I2C_END_OK) begin
          ack_st_n = ack_q;
          state_n  = S_CHECK;
        end else if (cnt == XFER_LAST) begin
          err_code_n = 2'd3;
          state_n    = S_ABORT;
        end
      end
      S_CHECK: begin
        if (ack_st) begin
          retry_n = '0;
          if (idx == IDX_LAST) begin
            state_n = S_FINISH;
          end else begin
            idx_n     = idx + 8'd1;
            refetch_n = 1'b1;
            state_n   = S_GAP;
          end
        end else if (retry < RETRY_MAX) begin
          retry_n   = retry + 8'd1;
          refetch_n = 1'b0;
          state_n   = S_GAP;
        end else begin
          err_code_n = 2'd1;
          state_n    = S_ABORT;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_n = refetch ? S_FETCH1 : S_GO_HI;
      end
      S_FINISH: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      S_ABORT: begin
        err_n     = 1'b1;
        err_idx_n = idx;
        busy_n    = 1'b0;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (state_n != state) cnt_n = '0;
    else if (cnt == '1)   cnt_n = cnt;
    else                  cnt_n = cnt + 13'd1;
  end

endmodule

// File: tb/tb_i2c_word_init_sequencer.sv
// Directed bench for i2c_word_init_sequencer with a behavioural engine model
// that logs every write (pointer, data, GO width, preceding idle cycles).
module tb_i2c_word_init_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  tbl_idx;
  logic [7:0]  tbl_pointer = '0;
  logic [15:0] tbl_data = '0;
  logic        i2c_go;
  logic [7:0]  i2c_slave_address;
  logic [7:0]  i2c_pointer;
  logic [15:0] i2c_wdata16;
  logic        end_ok;
  logic        ack_ok;
  logic        busy, done, err;
  logic [7:0]  err_idx;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  i2c_word_init_sequencer #(
    .NUM_WORDS (3),
    .SLAVE_ADDR(8'h90),
    .GO_PULSE  (4),
    .GAP_CYCLES(16),
    .MAX_RETRY (2),
    .START_TMO (64),
    .XFER_TMO  (4096)
  ) dut (
    .PT_CK            (clk),
    .RESET_N          (rst_n),
    .START            (start),
    .TBL_IDX          (tbl_idx),
    .TBL_POINTER      (tbl_pointer),
    .TBL_DATA         (tbl_data),
    .I2C_GO           (i2c_go),
    .I2C_SLAVE_ADDRESS(i2c_slave_address),
    .I2C_POINTER      (i2c_pointer),
    .I2C_WDATA16      (i2c_wdata16),
    .I2C_END_OK       (end_ok),
    .I2C_ACK_OK       (ack_ok),
    .BUSY             (busy),
    .DONE             (done),
    .ERR              (err),
    .ERR_IDX          (err_idx),
    .ERR_CODE         (err_code)
  );

  // Register table: one-cycle read latency from tbl_idx.
  logic [7:0]  tbl_ptr [0:3];
  logic [15:0] tbl_dat [0:3];
  always @(posedge clk) begin
    tbl_pointer <= tbl_ptr[tbl_idx[1:0]];
    tbl_data    <= tbl_dat[tbl_idx[1:0]];
  end

  // Engine model. mode 0: normal, 1: END_OK never falls, 2: END_OK never returns.
  int          eng_mode = 0;
  logic        nack_plan [0:63];
  int          wr_cnt = 0;
  logic [7:0]  wr_ptr [0:63];
  logic [15:0] wr_dat [0:63];
  int          wr_go  [0:63];
  int          wr_gap [0:63];
  logic        go_q;
  int          go_len, idle_len, gap_rec, eng_t;
  logic        cur_nack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      end_ok   <= 1'b1;
      ack_ok   <= 1'b0;
      go_q     <= 1'b0;
      go_len   <= 0;
      idle_len <= 0;
      gap_rec  <= 0;
      eng_t    <= 0;
      cur_nack <= 1'b0;
    end else begin
      go_q <= i2c_go;
      if (i2c_go) begin
        go_len <= go_len + 1;
        if (!go_q) begin
          gap_rec  <= idle_len;
          idle_len <= 0;
        end
      end else begin
        go_len   <= 0;
        idle_len <= idle_len + 1;
      end
      if (!i2c_go && go_q) begin
        if (wr_cnt < 64) begin
          wr_ptr[wr_cnt] <= i2c_pointer;
          wr_dat[wr_cnt] <= i2c_wdata16;
          wr_go[wr_cnt]  <= go_len;
          wr_gap[wr_cnt] <= gap_rec;
          cur_nack       <= nack_plan[wr_cnt];
        end
        wr_cnt <= wr_cnt + 1;
        if (eng_mode != 1) eng_t <= 1;
      end else if (eng_t != 0) begin
        eng_t <= eng_t + 1;
        if (eng_t == 3) begin
          end_ok <= 1'b0;
          ack_ok <= ~cur_nack;
        end
        if (eng_t == 23) begin
          eng_t <= 0;
          if (eng_mode == 0) begin
            end_ok <= 1'b1;
            ack_ok <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit ok = 1'b0;
    int n = 0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (!busy && (done || err)) ok = 1'b1;
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic wait_go_high(input int budget, input string tag);
    bit ok = 1'b0;
    int n = 0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (i2c_go) ok = 1'b1;
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic wait_go_fall(input int budget, input string tag);
    bit ok = 1'b0;
    bit seen = 1'b0;
    int n = 0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (i2c_go) seen = 1'b1;
      else if (seen) ok = 1'b1;
    end
    chk(tag, 32'(ok), 1);
  endtask

  task automatic load_default_table();
    tbl_ptr[0] = 8'h02; tbl_dat[0] = 16'h1234;
    tbl_ptr[1] = 8'h03; tbl_dat[1] = 16'hABCD;
    tbl_ptr[2] = 8'h01; tbl_dat[2] = 16'h0060;
    tbl_ptr[3] = 8'h00; tbl_dat[3] = 16'h0000;
  endtask

  logic [7:0]  exp_ptr [0:2];
  logic [15:0] exp_dat [0:2];
  int base;

  initial begin
    for (int i = 0; i < 64; i++) nack_plan[i] = 1'b0;
    load_default_table();
    exp_ptr[0] = 8'h02; exp_dat[0] = 16'h1234;
    exp_ptr[1] = 8'h03; exp_dat[1] = 16'hABCD;
    exp_ptr[2] = 8'h01; exp_dat[2] = 16'h0060;

    // Reset values
    #2;
    chk("rst_go",     32'(i2c_go), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_done",   32'(done), 0);
    chk("rst_err",    32'(err), 0);
    chk("rst_idx",    32'(tbl_idx), 0);
    chk("rst_code",   32'(err_code), 0);
    chk("rst_erridx", 32'(err_idx), 0);
    chk("rst_ptr",    32'(i2c_pointer), 0);
    chk("rst_wdata",  32'(i2c_wdata16), 0);
    chk("rst_saddr",  32'(i2c_slave_address), 32'h90);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: three entries, all ACK
    base = wr_cnt;
    pulse_start();
    chk("t1_busy", 32'(busy), 1);
    wait_done(2000, "t1_finish");
    chk("t1_nwr", 32'(wr_cnt - base), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_ptr%0d", i), 32'(wr_ptr[base+i]), 32'(exp_ptr[i]));
      chk($sformatf("t1_dat%0d", i), 32'(wr_dat[base+i]), 32'(exp_dat[i]));
      chk($sformatf("t1_go%0d", i),  32'(wr_go[base+i]), 4);
    end
    chk("t1_gap1", 32'(wr_gap[base+1]), 44);
    chk("t1_gap2", 32'(wr_gap[base+2]), 44);
    chk("t1_done", 32'(done), 1);
    chk("t1_err",  32'(err), 0);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_idx",  32'(tbl_idx), 2);
    chk("t1_code", 32'(err_code), 0);

    // T2: entry 1 NACKs once
    base = wr_cnt;
    nack_plan[base+1] = 1'b1;
    pulse_start();
    wait_done(2000, "t2_finish");
    chk("t2_nwr",  32'(wr_cnt - base), 4);
    chk("t2_ptr1", 32'(wr_ptr[base+1]), 32'h03);
    chk("t2_dat1", 32'(wr_dat[base+1]), 32'hABCD);
    chk("t2_ptr2", 32'(wr_ptr[base+2]), 32'h03);
    chk("t2_dat2", 32'(wr_dat[base+2]), 32'hABCD);
    chk("t2_gap_retry", 32'(wr_gap[base+2]), 42);
    chk("t2_ptr3", 32'(wr_ptr[base+3]), 32'h01);
    chk("t2_done", 32'(done), 1);
    chk("t2_err",  32'(err), 0);

    // T3: entry 2 NACKs permanently
    base = wr_cnt;
    nack_plan[base+2] = 1'b1;
    nack_plan[base+3] = 1'b1;
    nack_plan[base+4] = 1'b1;
    pulse_start();
    wait_done(2000, "t3_finish");
    chk("t3_nwr", 32'(wr_cnt - base), 5);
    for (int i = 2; i < 5; i++)
      chk($sformatf("t3_ptr%0d", i), 32'(wr_ptr[base+i]), 32'h01);
    chk("t3_err",    32'(err), 1);
    chk("t3_code",   32'(err_code), 1);
    chk("t3_erridx", 32'(err_idx), 2);
    chk("t3_done",   32'(done), 0);
    chk("t3_busy",   32'(busy), 0);

    // T4: end marker at entry 1; START after ERR restarts cleanly
    tbl_ptr[1] = 8'hFF; tbl_dat[1] = 16'hFFFF;
    base = wr_cnt;
    pulse_start();
    chk("t4_err_clr",    32'(err), 0);
    chk("t4_code_clr",   32'(err_code), 0);
    chk("t4_erridx_clr", 32'(err_idx), 0);
    chk("t4_idx0",       32'(tbl_idx), 0);
    chk("t4_busy",       32'(busy), 1);
    wait_done(2000, "t4_finish");
    chk("t4_nwr",  32'(wr_cnt - base), 1);
    chk("t4_ptr0", 32'(wr_ptr[base]), 32'h02);
    chk("t4_done", 32'(done), 1);
    chk("t4_err",  32'(err), 0);
    chk("t4_idx",  32'(tbl_idx), 1);
    load_default_table();

    // T5: END_OK never falls -> start timeout
    eng_mode = 1;
    pulse_start();
    wait_go_fall(200, "t5_go_fall");
    repeat (63) @(negedge clk);
    chk("t5_code_before", 32'(err_code), 0);
    @(negedge clk);
    chk("t5_code_at", 32'(err_code), 2);
    wait_done(20, "t5_finish");
    chk("t5_err",    32'(err), 1);
    chk("t5_erridx", 32'(err_idx), 0);
    chk("t5_done",   32'(done), 0);

    // T5b: END_OK never returns -> transfer timeout
    eng_mode = 2;
    pulse_start();
    begin
      bit ok = 1'b0;
      int n = 0;
      while (n < 200 && !ok) begin
        @(negedge clk);
        n++;
        if (!end_ok) ok = 1'b1;
      end
      chk("t5b_endok_fall", 32'(ok), 1);
    end
    repeat (4096) @(negedge clk);
    chk("t5b_code_before", 32'(err_code), 0);
    @(negedge clk);
    chk("t5b_code_at", 32'(err_code), 3);
    wait_done(20, "t5b_finish");
    chk("t5b_err",  32'(err), 1);
    chk("t5b_done", 32'(done), 0);

    // T6: reset while GO is high
    eng_mode = 0;
    pulse_start();
    wait_go_high(200, "t6_go_high");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_go",   32'(i2c_go), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_err",  32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 0);

    // T7: second START while busy is ignored
    base = wr_cnt;
    pulse_start();
    wait_go_fall(200, "t7_go_fall");
    pulse_start();
    wait_done(2000, "t7_finish");
    chk("t7_nwr",  32'(wr_cnt - base), 3);
    chk("t7_ptr2", 32'(wr_ptr[base+2]), 32'h01);
    chk("t7_done", 32'(done), 1);
    chk("t7_idx",  32'(tbl_idx), 2);
    repeat (10) @(negedge clk);
    chk("t7_no_restart", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
